// File: rtl/demux_1x8_reg_if.sv
// rtl/demux_1x8_reg_if.sv - source/consumer side bundle of the registered 1-to-8 demux
interface demux_1x8_reg_if #(
  parameter int W = 8
);
  // source side
  logic [W-1:0]   dado_in;
  logic [2:0]     endereco;
  logic           modo_auto;
  logic           valido_in;
  logic           reinicia_ptr;
  logic           pronto_out;
  // consumer side
  logic [7:0]     consumo;
  logic [8*W-1:0] saidas;
  logic [7:0]     saida_valida;
  // frame status
  logic [2:0]     ponteiro;
  logic           quadro_ok;

  modport master (
    output dado_in, endereco, modo_auto, valido_in, reinicia_ptr, consumo,
    input  pronto_out, saidas, saida_valida, ponteiro, quadro_ok
  );

  modport slave (
    input  dado_in, endereco, modo_auto, valido_in, reinicia_ptr, consumo,
    output pronto_out, saidas, saida_valida, ponteiro, quadro_ok
  );
endinterface

// File: rtl/demux_1x8_reg.sv
// rtl/demux_1x8_reg.sv - registered 1-to-8 demux with per-channel hold and auto-fill pointer
module demux_1x8_reg #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  demux_1x8_reg_if.slave  bus
);

  localparam logic [0:0] ESPERA   = 1'b0;
  localparam logic [0:0] ENCHENDO = 1'b1;

  logic [7:0][W-1:0] data_q, data_d;
  logic [7:0]        full_q, full_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [0:0]        state_q, state_d;
  logic              quadro_q, quadro_d;

  logic [2:0]        alvo;
  logic              pronto;
  logic              xfer;
  logic              auto_xfer;
  logic              wrap;

  // A channel can take a word when empty or when its consumer is draining it this cycle.
  assign alvo      = bus.modo_auto ? ptr_q : bus.endereco;
  assign pronto    = ~full_q[alvo] | bus.consumo[alvo];
  assign xfer      = bus.valido_in & pronto;
  assign auto_xfer = xfer & bus.modo_auto;

  assign bus.pronto_out   = pronto;
  assign bus.saidas       = data_q;
  assign bus.saida_valida = full_q;
  assign bus.ponteiro     = ptr_q;
  assign bus.quadro_ok    = quadro_q;

  // Channel storage: consumes clear flags, a transfer sets its flag last so it wins a same-cycle ack.
  always_comb begin
    data_d = data_q;
    full_d = full_q & ~bus.consumo;
    if (xfer) begin
      data_d[alvo] = bus.dado_in;
      full_d[alvo] = 1'b1;
    end
  end

  // Pointer FSM: clear beats increment; only an auto increment out of 7 counts as a completed frame.
  always_comb begin
    ptr_d = ptr_q;
    wrap  = 1'b0;
    if (bus.reinicia_ptr) begin
      ptr_d = 3'd0;
    end else if (auto_xfer) begin
      ptr_d = ptr_q + 3'd1;
      wrap  = (state_q == ENCHENDO) && (ptr_q == 3'd7);
    end
    state_d  = (ptr_d == 3'd0) ? ESPERA : ENCHENDO;
    quadro_d = wrap;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      full_q   <= '0;
      ptr_q    <= 3'd0;
      state_q  <= ESPERA;
      quadro_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      full_q   <= full_d;
      ptr_q    <= ptr_d;
      state_q  <= state_d;
      quadro_q <= quadro_d;
    end
  end

endmodule

// File: tb/tb_demux_1x8_reg.sv
// tb/tb_demux_1x8_reg.sv - scoreboard bench for the registered 1-to-8 demux
module tb_demux_1x8_reg;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_1x8_reg_if #(.W(W)) bus ();

  demux_1x8_reg #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: which channels hold a word, pointer, pending frame pulse
  bit [7:0]     m_full;
  int           m_ptr;
  bit           m_quadro;
  logic [W-1:0] sbq [8][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.valido_in    = 1'b0;
    bus.dado_in      = '0;
    bus.endereco     = 3'd0;
    bus.modo_auto    = 1'b0;
    bus.reinicia_ptr = 1'b0;
    bus.consumo      = 8'h00;
  endtask

  task automatic model_clear();
    m_full   = '0;
    m_ptr    = 0;
    m_quadro = 1'b0;
    for (int k = 0; k < 8; k++) sbq[k].delete();
  endtask

  // one clock of stimulus; state checks against the model, accepted words go to the scoreboard
  task automatic step(input bit v, input int addr, input bit au, input logic [W-1:0] d,
                      input bit rp, input logic [7:0] co);
    int tgt;
    bit xf;
    bit wrap;
    @(posedge clk);
    #1;
    bus.valido_in    = v;
    bus.endereco     = 3'(addr);
    bus.modo_auto    = au;
    bus.dado_in      = d;
    bus.reinicia_ptr = rp;
    bus.consumo      = co;
    @(negedge clk);
    tgt = au ? m_ptr : addr;
    chk("pronto_out", 64'(bus.pronto_out), 64'(!m_full[tgt] || co[tgt]));
    chk("saida_valida", 64'(bus.saida_valida), 64'(m_full));
    chk("ponteiro", 64'(bus.ponteiro), 64'(m_ptr));
    chk("quadro_ok", 64'(bus.quadro_ok), 64'(m_quadro));
    xf = v && (!m_full[tgt] || co[tgt]);
    m_full = m_full & ~co;
    if (xf) begin
      m_full[tgt] = 1'b1;
      sbq[tgt].push_back(d);
    end
    wrap = 1'b0;
    if (rp) m_ptr = 0;
    else if (au && xf) begin
      wrap  = (m_ptr == 7);
      m_ptr = (m_ptr + 1) % 8;
    end
    m_quadro = wrap;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valida"}, 64'(bus.saida_valida), 64'h0);
    chk({tag, "_ptr"}, 64'(bus.ponteiro), 64'h0);
    chk({tag, "_quadro"}, 64'(bus.quadro_ok), 64'h0);
    chk({tag, "_saidas"}, 64'(bus.saidas), 64'h0);
    chk({tag, "_pronto"}, 64'(bus.pronto_out), 64'h1);
  endtask

  // monitor: whenever a consumer acks a presented word, it must be the oldest one routed there
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        for (int k = 0; k < 8; k++) begin
          if (bus.consumo[k] && bus.saida_valida[k]) begin
            if (sbq[k].size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL sb_empty ch%0d: got %0h expected no word at %0t",
                       k, bus.saidas[k*W +: W], $time);
            end else begin
              chk($sformatf("sb_data_ch%0d", k), 64'(bus.saidas[k*W +: W]),
                  64'(sbq[k].pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin
    idle_inputs();
    model_clear();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // manual route, one-hot data to each channel
    for (int k = 0; k < 8; k++) step(1'b1, k, 1'b0, 8'(1 << k), 1'b0, 8'h00);
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00);

    // backpressure on full channel 3, then same-cycle ack and reload
    step(1'b1, 3, 1'b0, 8'h5A, 1'b0, 8'h00);
    step(1'b1, 3, 1'b0, 8'hA5, 1'b0, 8'h08);
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'hFF);
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'hFF);

    // auto frame with consumers acking every cycle
    for (int i = 0; i < 8; i++) step(1'b1, 0, 1'b1, 8'(8'h10 + i), 1'b0, 8'hFF);
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'hFF);

    // mode switch keeps pointer, clear wins over increment but the word still lands
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b1, 8'(8'h30 + i), 1'b0, 8'h00);
    step(1'b1, 6, 1'b0, 8'h66, 1'b0, 8'h00);
    step(1'b1, 0, 1'b1, 8'hC3, 1'b1, 8'h00);
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'hFF);
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00);

    // mid-frame asynchronous reset: ptr=5, channels 2..4 full
    for (int i = 0; i < 5; i++) step(1'b1, 0, 1'b1, 8'(8'h50 + i), 1'b0, 8'h00);
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h03);
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("pre_reset_ptr", 64'(bus.ponteiro), 64'd5);
    chk("pre_reset_valida", 64'(bus.saida_valida), 64'h1C);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    model_clear();
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), 1'($urandom),
           8'($urandom), ($urandom_range(0, 15) == 0), 8'($urandom & $urandom));
    end
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("sb_level_ch%0d", k), 64'(sbq[k].size()), 64'(m_full[k]));
      if (m_full[k] && sbq[k].size() != 0)
        chk($sformatf("held_ch%0d", k), 64'(bus.saidas[k*W +: W]), 64'(sbq[k][0]));
    end
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'hFF);
    step(1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
